// File: rtl/ether_rx_if.sv
// RMII receive bus: PHY-side dibit stream in, AXI-Stream-style word stream out.
interface ether_rx_if #(
  parameter int OUT_W = 8
);
  logic             crsdv;
  logic [1:0]       rxd;
  logic             axiov;
  logic [OUT_W-1:0] axiod;
  logic             axiol;
  logic             axioe;

  modport master (
    output crsdv, rxd,
    input  axiov, axiod, axiol, axioe
  );

  modport slave (
    input  crsdv, rxd,
    output axiov, axiod, axiol, axioe
  );
endinterface

// File: rtl/ether_rx.sv
// RMII receive front end: preamble/SFD check, dibit-to-word assembly, last/error tagging.
// Optional frame statistics ports are built when ETHER_RX_STATS_EN is defined.
module ether_rx #(
  parameter int OUT_W        = 8,
  parameter int PREAM_DIBITS = 32
) (
  input  logic       clk,
  input  logic       rst,
  ether_rx_if.slave  bus
`ifdef ETHER_RX_STATS_EN
  ,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad
`endif
);

  localparam int HALF = OUT_W / 2;
  localparam int KW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PW   = $clog2(PREAM_DIBITS) + 1;
  localparam logic [KW-1:0] K_LAST  = KW'(HALF - 1);
  localparam logic [PW-1:0] SFD_IDX = PW'(PREAM_DIBITS - 1);

  typedef enum logic [1:0] {IDLE, PREAM, DATA, BAD} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic [OUT_W-1:0] shreg_q, shreg_d;
  logic [OUT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             axiov_q, axiov_d;
  logic [OUT_W-1:0] axiod_q, axiod_d;
  logic             axiol_q, axiol_d;
  logic             axioe_q, axioe_d;
  logic [OUT_W-1:0] word_v;
  logic [1:0]       exp_dibit;

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    k_d        = k_q;
    shreg_d    = shreg_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    axiov_d    = 1'b0;
    axiod_d    = '0;
    axiol_d    = 1'b0;
    axioe_d    = 1'b0;
    exp_dibit  = (pcnt_q == SFD_IDX) ? 2'b11 : 2'b01;
    word_v     = shreg_q;
    for (int i = 0; i < HALF; i++) begin
      if (k_q == KW'(i)) word_v[2*i +: 2] = bus.rxd;
    end

    case (state_q)
      IDLE: begin
        if (bus.crsdv && bus.rxd == 2'b01) begin
          state_d = PREAM;
          pcnt_d  = PW'(1);
        end else if (bus.crsdv && bus.rxd[1]) begin
          state_d = BAD;
        end
      end
      PREAM: begin
        if (!bus.crsdv || bus.rxd != exp_dibit) begin
          state_d = BAD;
        end else if (pcnt_q == SFD_IDX) begin
          state_d    = DATA;
          k_d        = '0;
          shreg_d    = '0;
          pend_vld_d = 1'b0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bus.crsdv) begin
          if (k_q == K_LAST) begin
            // A completed word releases the previous one; it is now known not to be last.
            k_d        = '0;
            shreg_d    = '0;
            pend_d     = word_v;
            pend_vld_d = 1'b1;
            if (pend_vld_q) begin
              axiov_d = 1'b1;
              axiod_d = pend_q;
            end
          end else begin
            k_d     = k_q + 1'b1;
            shreg_d = word_v;
          end
        end else begin
          state_d    = IDLE;
          k_d        = '0;
          shreg_d    = '0;
          pend_vld_d = 1'b0;
          axiov_d    = 1'b1;
          axiol_d    = 1'b1;
          axiod_d    = pend_vld_q ? pend_q : '0;
          axioe_d    = pend_vld_q ? (k_q != '0) : 1'b1;
        end
      end
      BAD: begin
        if (!bus.crsdv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      k_q        <= '0;
      shreg_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      axiov_q    <= 1'b0;
      axiod_q    <= '0;
      axiol_q    <= 1'b0;
      axioe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      k_q        <= k_d;
      shreg_q    <= shreg_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      axiov_q    <= axiov_d;
      axiod_q    <= axiod_d;
      axiol_q    <= axiol_d;
      axioe_q    <= axioe_d;
    end
  end

  assign bus.axiov = axiov_q;
  assign bus.axiod = axiod_q;
  assign bus.axiol = axiol_q;
  assign bus.axioe = axioe_q;

`ifdef ETHER_RX_STATS_EN
  logic [15:0] frames_ok_q, frames_ok_d;
  logic [15:0] frames_bad_q, frames_bad_d;

  // Bad frames are preamble failures (any entry into BAD) plus frames closed on a partial word.
  always_comb begin
    frames_ok_d  = frames_ok_q;
    frames_bad_d = frames_bad_q;
    if (axiov_d && axiol_d && !axioe_d) frames_ok_d = frames_ok_q + 16'd1;
    if ((axiov_d && axiol_d && axioe_d) || (state_d == BAD && state_q != BAD))
      frames_bad_d = frames_bad_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frames_ok_q  <= '0;
      frames_bad_q <= '0;
    end else begin
      frames_ok_q  <= frames_ok_d;
      frames_bad_q <= frames_bad_d;
    end
  end

  assign frames_ok  = frames_ok_q;
  assign frames_bad = frames_bad_q;
`endif

endmodule

// File: tb/tb_ether_rx.sv
// Scoreboard bench for ether_rx (OUT_W=8, 32-dibit preamble); checks stats when ETHER_RX_STATS_EN is defined.
module tb_ether_rx;

  localparam int OUT_W = 8;
  localparam int PREAM = 32;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  byte unsigned pl[$];

`ifdef ETHER_RX_STATS_EN
  logic [15:0] frames_ok, frames_bad;
`endif

  ether_rx_if #(.OUT_W(OUT_W)) dut_if ();

  ether_rx #(.OUT_W(OUT_W), .PREAM_DIBITS(PREAM)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (dut_if)
`ifdef ETHER_RX_STATS_EN
    ,
    .frames_ok  (frames_ok),
    .frames_bad (frames_bad)
`endif
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push(input logic [7:0] d, input logic l, input logic e);
    exp_t x;
    x.d = d; x.l = l; x.e = e;
    sb.push_back(x);
  endfunction

  // Output monitor: every word popped against the scoreboard, quiet cycles must be all-zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dut_if.axiov) begin
        if (sb.size() == 0) begin
          chk("unexpected_axiov", {55'd0, dut_if.axiol, dut_if.axiod}, 64'd0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("axiod", 64'(dut_if.axiod), 64'(x.d));
          chk("axiol", 64'(dut_if.axiol), 64'(x.l));
          if (dut_if.axiol) chk("axioe", 64'(dut_if.axioe), 64'(x.e));
        end
      end else begin
        chk("quiet", {54'd0, dut_if.axiol, dut_if.axioe, dut_if.axiod}, 64'd0);
      end
    end
  end

  task automatic dib(input logic [1:0] d);
    @(negedge clk);
    dut_if.crsdv = 1'b1;
    dut_if.rxd   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dut_if.crsdv = 1'b0;
      dut_if.rxd   = 2'b00;
    end
  endtask

  task automatic pream(input int bad_idx);
    for (int i = 0; i < PREAM; i++) begin
      logic [1:0] d;
      d = (i == PREAM - 1) ? 2'b11 : 2'b01;
      if (i == bad_idx) d = 2'b00;
      dib(d);
    end
  endtask

  task automatic byte_tx(input logic [7:0] b);
    for (int j = 0; j < 4; j++) dib(b[2*j +: 2]);
  endtask

  // Sends preamble + pl[] (+ optional trailing dibit); expectations pushed only for good preambles.
  task automatic frame(input int bad_idx, input int extra);
    if (bad_idx < 0) begin
      if (pl.size() == 0) push(8'h00, 1'b1, 1'b1);
      for (int i = 0; i < pl.size(); i++)
        push(pl[i], i == pl.size() - 1, extra >= 0);
    end
    pream(bad_idx);
    for (int i = 0; i < pl.size(); i++) byte_tx(pl[i]);
    if (extra >= 0) dib(2'(extra));
    idle(1);
  endtask

  initial begin
    dut_if.crsdv = 1'b0;
    dut_if.rxd   = 2'b00;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_axiov", 64'(dut_if.axiov), 64'd0);
    chk("rst_axiod", 64'(dut_if.axiod), 64'd0);
    chk("rst_axiol_e", {62'd0, dut_if.axiol, dut_if.axioe}, 64'd0);
`ifdef ETHER_RX_STATS_EN
    chk("rst_stats", {32'd0, frames_ok, frames_bad}, 64'd0);
`endif
    rst_n = 1'b1;
    idle(2);

    pl = '{8'hA5, 8'h3C};
    frame(-1, -1);

    pl = '{8'hA5, 8'h3C};
    frame(19, -1);
    pl = '{8'h5A};
    frame(-1, -1);

    pl = '{8'hFF};
    frame(-1, 2);

    pl = '{};
    frame(-1, -1);
    idle(3);
`ifdef ETHER_RX_STATS_EN
    chk("frames_ok", 64'(frames_ok), 64'd2);
    chk("frames_bad", 64'(frames_bad), 64'd3);
`endif

    // Reset mid-payload: 0x11 complete, 0x22 half-received.
    pream(-1);
    byte_tx(8'h11);
    dib(2'b10);
    dib(2'b00);
    @(negedge clk);
    rst_n = 1'b0;
    dut_if.rxd = 2'b10;
    #1;
    chk("midrst_outs", {54'd0, dut_if.axiov, dut_if.axiol, dut_if.axiod}, 64'd0);
    dib(2'b00);
    dib(2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    dut_if.rxd = 2'b00;
    byte_tx(8'h33);
    byte_tx(8'h44);
    idle(1);

    pl = '{8'hC3};
    frame(-1, -1);

    for (int f = 0; f < 4; f++) begin
      int n;
      n = $urandom_range(1, 5);
      pl = '{};
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
      frame(-1, (f == 2) ? 1 : -1);
    end

    idle(6);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
